// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: 3-entry write scoreboard, RAW stall, branch flush, HALT drain FSM.
// Control outputs are combinational from inputs and state; counters saturate.
module pipe_hazard_ctrl #(
  parameter int         FORWARD = 1,
  parameter logic [5:0] HALT_OP = 6'b010001,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_writes_reg,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] dest;
    logic       is_load;
  } sb_t;

  state_t           state_q, state_d;
  sb_t              sb_ex_q, sb_ex_d;
  sb_t              sb_mem_q, sb_mem_d;
  sb_t              sb_wb_q, sb_wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic run;
  logic hit_ex, hit_mem, hit_wb;
  logic raw_hit;
  logic advance;

  function automatic logic src_hit(input sb_t e, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic use_rs, input logic use_rt);
    return e.vld & ((use_rs & (rs == e.dest)) | (use_rt & (rt == e.dest)));
  endfunction

  always_comb begin
    run     = (state_q == RUN);
    hit_ex  = src_hit(sb_ex_q,  id_rs, id_rt, id_uses_rs, id_uses_rt);
    hit_mem = src_hit(sb_mem_q, id_rs, id_rt, id_uses_rs, id_uses_rt);
    hit_wb  = src_hit(sb_wb_q,  id_rs, id_rt, id_uses_rs, id_uses_rt);

    // With forwarding only a load still in EX cannot supply its result in time.
    if (FORWARD != 0) raw_hit = id_valid & hit_ex & sb_ex_q.is_load;
    else              raw_hit = id_valid & (hit_ex | hit_mem | hit_wb);

    flush_id  = ex_branch_taken & run;
    stall     = (raw_hit & ~ex_branch_taken) | ~run;
    bubble_ex = flush_id | stall;
    halted    = (state_q == HALTED);
    state     = state_q;
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
    advance   = id_valid & ~stall & ~flush_id & run;
  end

  always_comb begin
    sb_ex_d  = '0;
    sb_mem_d = sb_ex_q;
    sb_wb_d  = sb_mem_q;
    if (advance && id_writes_reg && (id_dest != 5'd0)) begin
      sb_ex_d = '{vld: 1'b1, dest: id_dest, is_load: id_is_load};
    end

    state_d = state_q;
    case (state_q)
      RUN: begin
        if (id_valid && (id_opcode == HALT_OP) && !stall && !ex_branch_taken) state_d = DRAIN;
      end
      DRAIN: begin
        if (!(sb_ex_q.vld || sb_mem_q.vld || sb_wb_q.vld)) state_d = HALTED;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall && run && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush_id && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      sb_ex_q     <= '0;
      sb_mem_q    <= '0;
      sb_wb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sb_ex_q     <= sb_ex_d;
      sb_mem_q    <= sb_mem_d;
      sb_wb_q     <= sb_wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations (forwarding, no forwarding, 4-bit counters)
// share one input stream and are compared every cycle against a reference model.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] HALT = 6'b010001;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs, id_uses_rt, id_writes_reg, id_is_load, ex_branch_taken;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_dest;

  logic [2:0]  d_stall, d_flush, d_bubble, d_halted;
  logic [1:0]  st0, st1, st2;
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FORWARD(1), .HALT_OP(HALT), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_writes_reg(id_writes_reg),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .stall(d_stall[0]), .flush_id(d_flush[0]),
    .bubble_ex(d_bubble[0]), .halted(d_halted[0]), .state(st0), .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_hazard_ctrl #(.FORWARD(0), .HALT_OP(HALT), .CNT_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_writes_reg(id_writes_reg),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .stall(d_stall[1]), .flush_id(d_flush[1]),
    .bubble_ex(d_bubble[1]), .halted(d_halted[1]), .state(st1), .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_hazard_ctrl #(.FORWARD(0), .HALT_OP(HALT), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_writes_reg(id_writes_reg),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .stall(d_stall[2]), .flush_id(d_flush[2]),
    .bubble_ex(d_bubble[2]), .halted(d_halted[2]), .state(st2), .stall_cnt(sc2), .flush_cnt(fc2));

  // Reference model: per configuration, the writers issued 1, 2 and 3 cycles ago.
  typedef struct { bit v; int dest; bit ld; } wr_t;
  wr_t inflight[3][3];
  int  m_state[3];
  int  m_scnt[3];
  int  m_fcnt[3];
  int  sat_max[3] = '{65535, 65535, 15};
  bit  fwd_cfg[3] = '{1'b1, 1'b0, 1'b0};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_hit(input int c);
    bit h = 0;
    if (!id_valid) return 0;
    for (int age = 0; age < 3; age++) begin
      wr_t w = inflight[c][age];
      bit reads = (id_uses_rs && int'(id_rs) == w.dest) || (id_uses_rt && int'(id_rt) == w.dest);
      if (w.v && reads && (!fwd_cfg[c] || (age == 0 && w.ld))) h = 1;
    end
    return h;
  endfunction

  function automatic bit m_stall(input int c);
    return (m_state[c] != 0) || (m_hit(c) && !ex_branch_taken);
  endfunction

  function automatic bit m_flush(input int c);
    return (m_state[c] == 0) && ex_branch_taken;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 3; c++) begin
      for (int a = 0; a < 3; a++) inflight[c][a] = '{0, 0, 0};
      m_state[c] = 0; m_scnt[c] = 0; m_fcnt[c] = 0;
    end
  endtask

  task automatic m_clock();
    for (int c = 0; c < 3; c++) begin
      bit s = m_stall(c);
      bit f = m_flush(c);
      bit issue = id_valid && !s && !f && m_state[c] == 0;
      bit empty = !inflight[c][0].v && !inflight[c][1].v && !inflight[c][2].v;
      if (s && m_state[c] == 0 && m_scnt[c] < sat_max[c]) m_scnt[c]++;
      if (f && m_fcnt[c] < sat_max[c]) m_fcnt[c]++;
      if (m_state[c] == 0 && issue && id_opcode == HALT) m_state[c] = 1;
      else if (m_state[c] == 1 && empty) m_state[c] = 2;
      inflight[c][2] = inflight[c][1];
      inflight[c][1] = inflight[c][0];
      inflight[c][0] = '{issue && id_writes_reg && id_dest != 0, int'(id_dest), id_is_load};
    end
  endtask

  function automatic logic [31:0] dut_state(input int c);
    return (c == 0) ? 32'(st0) : (c == 1) ? 32'(st1) : 32'(st2);
  endfunction
  function automatic logic [31:0] dut_scnt(input int c);
    return (c == 0) ? 32'(sc0) : (c == 1) ? 32'(sc1) : 32'(sc2);
  endfunction
  function automatic logic [31:0] dut_fcnt(input int c);
    return (c == 0) ? 32'(fc0) : (c == 1) ? 32'(fc1) : 32'(fc2);
  endfunction

  // Inputs are already applied (just after a posedge); compare mid-cycle, then clock the model.
  task automatic step();
    if (rst) m_reset();
    #3;
    for (int c = 0; c < 3; c++) begin
      bit s = m_stall(c);
      bit f = m_flush(c);
      chk($sformatf("stall[%0d]", c),     32'(d_stall[c]),  32'(s));
      chk($sformatf("flush_id[%0d]", c),  32'(d_flush[c]),  32'(f));
      chk($sformatf("bubble_ex[%0d]", c), 32'(d_bubble[c]), 32'(s | f));
      chk($sformatf("halted[%0d]", c),    32'(d_halted[c]), 32'(m_state[c] == 2));
      chk($sformatf("state[%0d]", c),     dut_state(c),     32'(m_state[c]));
      chk($sformatf("stall_cnt[%0d]", c), dut_scnt(c),      32'(m_scnt[c]));
      chk($sformatf("flush_cnt[%0d]", c), dut_fcnt(c),      32'(m_fcnt[c]));
    end
    @(posedge clk);
    if (!rst) m_clock();
    #1;
  endtask

  task automatic drive(input bit v, input logic [5:0] op, input int rs, input int rt, input bit urs,
                       input bit urt, input int dst, input bit wr, input bit ld, input bit br);
    id_valid = v; id_opcode = op; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_dest = 5'(dst); id_writes_reg = wr; id_is_load = ld; ex_branch_taken = br;
  endtask

  task automatic idle(input int n);
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  task automatic do_reset();
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    @(negedge clk);
    step();
    rst = 1'b0;
    idle(1);

    // Load-use: lw r5 then add reading r5, held in ID while stalled.
    drive(1, 6'b100011, 0, 0, 0, 0, 5, 1, 1, 0); step();
    drive(1, 6'b000000, 5, 0, 1, 0, 0, 0, 0, 0); repeat (4) step();
    idle(3);
    chk("loaduse_fwd_stall_cnt", 32'(sc0), 32'd1);
    chk("loaduse_nofwd_stall_cnt", 32'(sc1), 32'd3);

    // Register 0 writer and an unused matching rt never stall.
    do_reset();
    drive(1, 6'd0, 0, 0, 0, 0, 0, 1, 1, 0); step();
    drive(1, 6'd0, 0, 0, 1, 0, 0, 0, 0, 0); step();
    drive(1, 6'd0, 0, 0, 0, 0, 4, 1, 1, 0); step();
    drive(1, 6'd0, 0, 4, 0, 0, 0, 0, 0, 0); step();
    idle(3);
    chk("r0_nofwd_stall_cnt", 32'(sc1), 32'd0);

    // Branch taken in the same cycle as a load-use hit.
    do_reset();
    drive(1, 6'b100011, 0, 0, 0, 0, 6, 1, 1, 0); step();
    drive(1, 6'd0, 6, 0, 1, 0, 0, 0, 0, 1); step();
    idle(3);
    chk("branch_fwd_flush_cnt", 32'(fc0), 32'd1);
    chk("branch_fwd_stall_cnt", 32'(sc0), 32'd0);
    chk("branch_fwd_state", 32'(st0), 32'd0);

    // HALT behind three writers, then noise while halted, then reset.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 6'd0, 0, 0, 0, 0, i, 1, 0, 0); step();
    end
    drive(1, HALT, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("halt_fwd_drain", 32'(st0), 32'd1);
    drive(1, 6'd0, 1, 2, 1, 1, 7, 1, 1, 1); repeat (3) step();
    chk("halt_fwd_halted", 32'(st0), 32'd2);
    drive(1, 6'd0, 3, 3, 1, 1, 3, 1, 1, 1); repeat (4) step();
    chk("halt_noise_flush_cnt", 32'(fc0), 32'd0);
    do_reset();
    chk("halt_reset_state", 32'(st0), 32'd0);
    chk("halt_reset_stall_cnt", 32'(sc1), 32'd0);

    // Saturation: seven 3-cycle RAW stalls without forwarding.
    for (int k = 0; k < 7; k++) begin
      drive(1, 6'd0, 0, 0, 0, 0, 3, 1, 0, 0); step();
      drive(1, 6'd0, 0, 3, 0, 1, 0, 0, 0, 0); repeat (4) step();
    end
    idle(2);
    chk("sat_stall_cnt", 32'(sc2), 32'd15);
    chk("nosat_stall_cnt", 32'(sc1), 32'd21);

    // Randomized traffic with occasional HALT and reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(59) == 0 || (m_state[0] == 2 && $urandom_range(3) == 0)) begin
        do_reset();
      end else begin
        drive($urandom_range(9) != 0,
              ($urandom_range(29) == 0) ? HALT : 6'($urandom_range(63)),
              $urandom_range(7), $urandom_range(7),
              $urandom_range(3) != 0, $urandom_range(3) != 0,
              $urandom_range(7), $urandom_range(3) != 0, $urandom_range(2) == 0,
              $urandom_range(6) == 0);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
